// File: rtl/serializer_pkg.sv
// Shared constants, state encoding and sizing helper for the output serializer.
package serializer_pkg;

    localparam int ENCRYPTER_WIDTH      = 32;
    localparam int NUM_ENCRYPTERS       = 4;
    localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / 4;

    typedef enum logic {
        SER_STATE_IDLE  = 1'b0,
        SER_STATE_SHIFT = 1'b1
    } ser_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_if.sv
// Encrypter-result and QSPI-output signals of the serializer, grouped as one bundle.
interface serializer_if #(
    parameter int DATA_WIDTH = serializer_pkg::ENCRYPTER_WIDTH,
    parameter int NUM_ENC    = serializer_pkg::NUM_ENCRYPTERS
);
    logic                          stream_start;
    logic [NUM_ENC*DATA_WIDTH-1:0] enc_result;
    logic [NUM_ENC-1:0]            enc_result_valid;
    logic [NUM_ENC-1:0]            enc_result_ack;
    logic [3:0]                    qspi_data;
    logic                          qspi_sending;
    logic                          qspi_ready;

    modport master (
        input  stream_start, enc_result, enc_result_valid, qspi_ready,
        output enc_result_ack, qspi_data, qspi_sending
    );

    modport slave (
        output stream_start, enc_result, enc_result_valid, qspi_ready,
        input  enc_result_ack, qspi_data, qspi_sending
    );
endinterface

// File: rtl/serializer_nibble_shifter.sv
// Word holding register with nibble counter; presents the current nibble, LS nibble first.
module serializer_nibble_shifter
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = ENCRYPTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [3:0]            nibble,
    output logic                  last
);
    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int CNT_W   = ptr_width(NIBBLES);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      count;

    // count parks on the last nibble after a word so qspi_data holds while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= din;
            count <= '0;
        end else if (advance && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last   = (count == CNT_W'(NIBBLES - 1));
    assign nibble = shreg[count*4 +: 4];

endmodule

// File: rtl/serializer.sv
// Round-robin collector of encrypter results, streamed out as QSPI nibbles.
//   state | meaning
//   IDLE  | waiting for valid on the pointed-to encrypter
//   SHIFT | emitting the captured word, one nibble per qspi_ready beat
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = ENCRYPTER_WIDTH,
    parameter int NUM_ENC    = NUM_ENCRYPTERS
) (
    input  logic        clk,
    input  logic        reset,
    serializer_if.master bus
);
    localparam int PTR_W = ptr_width(NUM_ENC);

    ser_state_t            state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      sel_ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic                  pending;
    logic                  capture;
    logic                  advance;
    logic                  last;
    logic                  sending;
    logic [3:0]            nibble;
    logic [NUM_ENC-1:0]    ack;
    logic [DATA_WIDTH-1:0] sel_word;

    // sel_ptr is the encrypter looked at this edge, after any restart to 0
    always_comb begin
        sel_ptr = ptr;
        capture = 1'b0;
        advance = (state == SER_STATE_SHIFT) && bus.qspi_ready;
        if (state == SER_STATE_IDLE) begin
            if (bus.stream_start) sel_ptr = '0;
            capture = bus.enc_result_valid[sel_ptr];
        end else if (advance && last) begin
            if (pending || bus.stream_start) sel_ptr = '0;
            capture = bus.enc_result_valid[sel_ptr];
        end
        ptr_next = (sel_ptr == PTR_W'(NUM_ENC - 1)) ? '0 : sel_ptr + 1'b1;
        sel_word = bus.enc_result[sel_ptr*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SER_STATE_IDLE;
            ptr     <= '0;
            pending <= 1'b0;
            ack     <= '0;
            sending <= 1'b0;
        end else begin
            ack <= '0;
            if (capture) begin
                ack[sel_ptr] <= 1'b1;
                ptr          <= ptr_next;
                state        <= SER_STATE_SHIFT;
                sending      <= 1'b1;
                pending      <= 1'b0;
            end else begin
                ptr <= sel_ptr;
                if (state == SER_STATE_SHIFT) begin
                    if (advance && last) begin
                        state   <= SER_STATE_IDLE;
                        sending <= 1'b0;
                        pending <= 1'b0;
                    end else if (bus.stream_start) begin
                        pending <= 1'b1;
                    end
                end
            end
        end
    end

    serializer_nibble_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (capture),
        .advance(advance),
        .din    (sel_word),
        .nibble (nibble),
        .last   (last)
    );

    assign bus.enc_result_ack = ack;
    assign bus.qspi_sending   = sending;
    assign bus.qspi_data      = nibble;

endmodule

// File: tb/tb_serializer.sv
// Directed and randomized bench for serializer; expected stream is the round-robin interleave of encrypter queues.
module tb_serializer;
    localparam int DW  = 32;
    localparam int NE  = 4;
    localparam int NIB = serializer_pkg::ENCRYPTER_QSPI_COUNT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serializer_if #(.DATA_WIDTH(DW), .NUM_ENC(NE)) bus();

    serializer #(.DATA_WIDTH(DW), .NUM_ENC(NE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sending_cycles = 0;

    // per-encrypter FIFO of results waiting to be offered
    logic [DW-1:0] enc_mem [NE][16];
    int head [NE];
    int tail [NE];

    logic [3:0]    beats [$];
    int            ack_idx [$];
    int            ack_cyc [$];
    logic [DW-1:0] exp_words [$];
    int            exp_acks [$];

    logic [DW-1:0] rw [NE][3];
    int pushed [NE];
    int budget;
    int ri;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_enc();
        for (int i = 0; i < NE; i++) begin
            bus.enc_result_valid[i] = (head[i] != tail[i]);
            bus.enc_result[i*DW +: DW] = (head[i] != tail[i]) ? enc_mem[i][head[i] % 16] : '0;
        end
    endtask

    task automatic push_word(input int i, input logic [DW-1:0] w);
        enc_mem[i][tail[i] % 16] = w;
        tail[i]++;
        drive_enc();
    endtask

    task automatic tick();
        if (bus.qspi_sending && bus.qspi_ready && !reset) beats.push_back(bus.qspi_data);
        @(posedge clk);
        #1;
        cyc++;
        if (bus.qspi_sending) sending_cycles++;
        for (int i = 0; i < NE; i++) begin
            if (bus.enc_result_ack[i]) begin
                ack_idx.push_back(i);
                ack_cyc.push_back(cyc);
                if (head[i] != tail[i]) head[i]++;
            end
        end
        drive_enc();
    endtask

    task automatic clear_log();
        beats.delete();
        ack_idx.delete();
        ack_cyc.delete();
        exp_words.delete();
        exp_acks.delete();
        sending_cycles = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.stream_start = 1'b0;
        for (int i = 0; i < NE; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive_enc();
        tick();
        tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 64'(beats.size()), 64'(exp_words.size() * NIB));
        for (int w = 0; w < exp_words.size(); w++)
            for (int n = 0; n < NIB; n++)
                if (w * NIB + n < beats.size())
                    check({tag, "_nib"}, 64'(beats[w*NIB+n]), 64'((exp_words[w] >> (4*n)) & 32'hF));
    endtask

    task automatic check_acks(input string tag);
        check({tag, "_ack_len"}, 64'(ack_idx.size()), 64'(exp_acks.size()));
        for (int k = 0; k < exp_acks.size(); k++)
            if (k < ack_idx.size()) check({tag, "_ack_idx"}, 64'(ack_idx[k]), 64'(exp_acks[k]));
    endtask

    initial begin
        reset = 1'b1;
        bus.qspi_ready = 1'b0;
        bus.stream_start = 1'b0;
        bus.enc_result = '0;
        bus.enc_result_valid = '0;
        do_reset();
        check("rst_sending", 64'(bus.qspi_sending), 64'd0);
        check("rst_data", 64'(bus.qspi_data), 64'd0);
        check("rst_ack", 64'(bus.enc_result_ack), 64'd0);

        // basic word
        bus.qspi_ready = 1'b1;
        push_word(0, 32'h89ABCDEF);
        exp_words.push_back(32'h89ABCDEF);
        exp_acks.push_back(0);
        tick();
        check("t1_ack", 64'(bus.enc_result_ack), 64'h1);
        check("t1_first", 64'(bus.qspi_data), 64'hF);
        tick();
        check("t1_ack_pulse", 64'(bus.enc_result_ack), 64'h0);
        repeat (7) tick();
        check("t1_idle", 64'(bus.qspi_sending), 64'd0);
        check("t1_sending_cycles", 64'(sending_cycles), 64'd8);
        check_stream("t1");
        check_acks("t1");

        // round robin, back-to-back
        do_reset();
        bus.qspi_ready = 1'b1;
        for (int i = 0; i < NE; i++) begin
            push_word(i, {8{4'(i + 1)}});
            exp_words.push_back({8{4'(i + 1)}});
            exp_acks.push_back(i);
        end
        repeat (40) tick();
        check("t2_sending_cycles", 64'(sending_cycles), 64'd32);
        check_stream("t2");
        check_acks("t2");
        for (int k = 1; k < ack_cyc.size(); k++)
            check("t2_ack_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd8);

        // no skipping, then wrap
        do_reset();
        bus.qspi_ready = 1'b1;
        push_word(1, 32'hA1A2A3A4);
        repeat (10) tick();
        check("t3_no_beats", 64'(beats.size()), 64'd0);
        check("t3_no_ack", 64'(ack_idx.size()), 64'd0);
        check("t3_idle", 64'(bus.qspi_sending), 64'd0);
        push_word(0, 32'h0B0C0D0E);
        exp_words.push_back(32'h0B0C0D0E);
        exp_words.push_back(32'hA1A2A3A4);
        exp_acks.push_back(0);
        exp_acks.push_back(1);
        repeat (20) tick();
        check_stream("t3a");
        check_acks("t3a");
        clear_log();
        push_word(2, 32'h22223333);
        push_word(3, 32'h44445555);
        push_word(0, 32'h66667777);
        exp_words.push_back(32'h22223333);
        exp_words.push_back(32'h44445555);
        exp_words.push_back(32'h66667777);
        exp_acks.push_back(2);
        exp_acks.push_back(3);
        exp_acks.push_back(0);
        repeat (30) tick();
        check_stream("t3b");
        check_acks("t3b");

        // stall at nibble 4
        do_reset();
        bus.qspi_ready = 1'b1;
        push_word(0, 32'h76543210);
        exp_words.push_back(32'h76543210);
        tick();
        repeat (4) tick();
        check("t4_at_nib4", 64'(bus.qspi_data), 64'h4);
        bus.qspi_ready = 1'b0;
        repeat (3) begin
            tick();
            check("t4_stall_data", 64'(bus.qspi_data), 64'h4);
            check("t4_stall_sending", 64'(bus.qspi_sending), 64'd1);
        end
        bus.qspi_ready = 1'b1;
        repeat (6) tick();
        check("t4_sending_cycles", 64'(sending_cycles), 64'd11);
        check_stream("t4");

        // stream_start during encrypter 1's word
        do_reset();
        bus.qspi_ready = 1'b1;
        push_word(0, 32'h10101010);
        push_word(1, 32'h21212121);
        tick();
        repeat (8) tick();
        repeat (3) tick();
        push_word(0, 32'h0F0E0D0C);
        push_word(2, 32'h2C2C2C2C);
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        repeat (30) tick();
        exp_words.push_back(32'h10101010);
        exp_words.push_back(32'h21212121);
        exp_words.push_back(32'h0F0E0D0C);
        exp_acks.push_back(0);
        exp_acks.push_back(1);
        exp_acks.push_back(0);
        check_stream("t5");
        check_acks("t5");
        check("t5_idle", 64'(bus.qspi_sending), 64'd0);

        // reset mid-word
        do_reset();
        bus.qspi_ready = 1'b1;
        push_word(0, 32'hFEDCBA98);
        tick();
        repeat (3) tick();
        check("t6_nib3", 64'(bus.qspi_data), 64'hB);
        reset = 1'b1;
        tick();
        check("t6_sending_off", 64'(bus.qspi_sending), 64'd0);
        check("t6_ack_clear", 64'(bus.enc_result_ack), 64'd0);
        reset = 1'b0;
        clear_log();
        push_word(1, 32'h5A5A1234);
        push_word(0, 32'hC3C39876);
        exp_words.push_back(32'hC3C39876);
        exp_words.push_back(32'h5A5A1234);
        exp_acks.push_back(0);
        exp_acks.push_back(1);
        repeat (25) tick();
        check_stream("t6");
        check_acks("t6");

        // randomized arrival and back-pressure
        do_reset();
        for (int i = 0; i < NE; i++) begin
            pushed[i] = 0;
            for (int k = 0; k < 3; k++) rw[i][k] = $urandom;
        end
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NE; i++) begin
                exp_words.push_back(rw[i][k]);
                exp_acks.push_back(i);
            end
        budget = 0;
        while (beats.size() < NE * 3 * NIB && budget < 3000) begin
            bus.qspi_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) begin
                ri = $urandom_range(0, NE - 1);
                if (pushed[ri] < 3) begin
                    push_word(ri, rw[ri][pushed[ri]]);
                    pushed[ri]++;
                end
            end
            tick();
            budget++;
        end
        check("rand_in_budget", 64'(budget < 3000), 64'd1);
        bus.qspi_ready = 1'b1;
        repeat (3) tick();
        check_stream("rand");
        check_acks("rand");
        check("rand_idle", 64'(bus.qspi_sending), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Output-side counterpart of the input parallelizer.
- Collects encrypted result words from the NUM_ENC encrypters in strict round-robin order (0,1,…,NUM_ENC-1,0,…). This is the same order in which packets were dispatched, so stream order is preserved.
- Streams each word out over the 4-bit QSPI link, one nibble per accepted beat, least-significant nibble first.
- Sits between the encrypter array and the QSPI output pins.

Parameters:
- DATA_WIDTH, 32, encrypter result word width in bits; must be a multiple of 4 (equals `ENCRYPTER_WIDTH).
- NUM_ENC, 4, number of encrypters (equals `NUM_ENCRYPTERS).
- NIBBLES, DATA_WIDTH/4, nibbles per word (equals `ENCRYPTER_QSPI_COUNT).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- stream_start  in  1  one-cycle pulse; restarts round-robin pointer at encrypter 0.
- enc_result  in  NUM_ENC*DATA_WIDTH  flattened result words; encrypter i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- enc_result_valid  in  NUM_ENC  encrypter i holds a finished result.
- enc_result_ack  out  NUM_ENC  one-cycle pulse; word from encrypter i captured.
- qspi_data  out  4  current nibble.
- qspi_sending  out  1  qspi_data is valid.
- qspi_ready  in  1  downstream accepts the nibble at this edge.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: qspi_data=0, qspi_sending=0, enc_result_ack=0, rr pointer=0, nibble count=0, state=IDLE, pending-start flag=0. Reset has priority over every other input.
- States: IDLE, SHIFT.
- IDLE:
  - At an edge with enc_result_valid[ptr]=1, capture enc_result[ptr] into the shift register.
  - ack[ptr]=1 for exactly the next cycle.
  - ptr wraps: ptr = (ptr==NUM_ENC-1) ? 0 : ptr+1.
  - count=0, go to SHIFT.
  - Valid from any non-pointer encrypter is ignored (no skipping).
- SHIFT:
  - qspi_sending=1.
  - qspi_data = shreg[count*4 +: 4].
  - Beat = edge with qspi_ready=1: count increments.
  - qspi_ready=0: nibble and count hold (stall), qspi_sending stays 1.
- Last-nibble boundary (count==NIBBLES-1) at a beat:
  - If enc_result_valid[ptr]=1 at the same edge: capture back-to-back, ack, advance ptr, count=0, stay in SHIFT. qspi_sending never drops, so there is zero bubble between words.
  - Otherwise: go to IDLE; qspi_sending=0 from the next cycle.
- Latency: capture edge to first nibble on qspi_data is 1 cycle. A word occupies exactly NIBBLES beats.
- Ack rule: the encrypter must drop valid, or present a new result, by the edge after its ack cycle. The serializer never samples the same encrypter twice within NIBBLES cycles.
- stream_start:
  - In IDLE: ptr=0 at that edge. If valid[0] is also set at that edge, encrypter 0 is captured.
  - In SHIFT: latched into the pending flag and applied (ptr=0) when the current word completes. Back-to-back capture at that boundary then uses encrypter 0.
- Reset mid-word: the word is discarded, no further nibbles are emitted, qspi_sending=0 the following cycle, and any pending ack is cleared.
- qspi_data holds its last value while qspi_sending=0.

Decomposition:
- constants.vh holds `ENCRYPTER_WIDTH, `NUM_ENCRYPTERS, `ENCRYPTER_QSPI_COUNT, and the serializer state encodings (SER_STATE_IDLE=1'b0, SER_STATE_SHIFT=1'b1).
- Sub-module nibble_shifter holds the DATA_WIDTH load register, the nibble count, and the nibble mux.
  - Inputs: load, advance.
  - Outputs: nibble, last.
- The FSM, round-robin pointer, and ack generation stay in serializer.

Test Plan:
- Basic word: reset, then valid[0]=1 with enc_result[31:0]=0x89ABCDEF and qspi_ready=1 → ack[0] for one cycle; nibbles F,E,D,C,B,A,9,8 on 8 consecutive cycles; qspi_sending then 0.
- Round-robin order: all four valid, words 0x11111111/0x22222222/0x33333333/0x44444444 → 32 contiguous nibbles 1…,2…,3…,4…; acks 0,1,2,3 eight cycles apart; qspi_sending high for exactly 32 cycles.
- Ordering and wrap: valid[1] only → no output and no ack. Then valid[0]=1 → word 0 is sent, then word 1. After encrypter 3, the next capture is encrypter 0.
- Stall: qspi_ready low for 3 cycles at nibble 4 of 0x76543210 → qspi_data holds 4 and qspi_sending stays 1; the word completes in 11 cycles total.
- stream_start mid-word: pulse during encrypter 1's word with valid[0] and valid[2] set → the next capture is encrypter 0, not encrypter 2.
- Reset mid-word: reset at nibble 3 → qspi_sending=0 the next cycle; ptr=0; a subsequent valid[0] transmits from nibble 0.
